// File: rtl/bit_packer_pkg.sv
// Shared types and helpers for the bit packer: counter sizing, handshake struct,
// and default geometry.
package bit_packer_pkg;

    localparam int DEFAULT_WIDTH  = 4;
    localparam int DEFAULT_LANES  = 1;
    localparam int BEATS_PER_WORD = DEFAULT_WIDTH / DEFAULT_LANES;

    // Bits needed to hold a count from 0 up to and including width.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    typedef struct packed {
        logic valid;
        logic last;
    } beat_hs_t;

endpackage

// File: rtl/bit_packer_if.sv
// Input-beat and output-word handshake bundle for the bit packer.
interface bit_packer_if #(
    parameter int WIDTH = 4,
    parameter int LANES = 1
);
    import bit_packer_pkg::*;

    localparam int CW = cnt_w(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] in_bits;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;

    modport master (
        output in_valid, in_bits, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );

    modport slave (
        input  in_valid, in_bits, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );

endinterface

// File: rtl/bit_packer_accumulator.sv
// Shift register and bit counter that gathers beats into a word and flags the
// beat that completes it, presenting the finished word combinationally.
module bit_packer_accumulator
    import bit_packer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             accept,
    input  logic [LANES-1:0] bits,
    input  logic             last,
    output logic [CW-1:0]    cnt,
    output logic             done,
    output logic [WIDTH-1:0] word_data,
    output logic [CW-1:0]    word_count
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt_sum;

    assign cnt_sum = cnt + CW'(LANES);

    // Valid bits always sit at the bottom of acc; MSB-first shifts older bits up,
    // LSB-first drops each new beat in just above the bits already held.
    always_comb begin
        acc_next = acc;
        if (MSB_FIRST)
            acc_next = (acc << LANES) | WIDTH'(bits);
        else
            acc_next = acc | (WIDTH'(bits) << cnt);
    end

    assign done       = accept && (last || (cnt_sum == CW'(WIDTH)));
    assign word_data  = acc_next;
    assign word_count = cnt_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear || done) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= acc_next;
            cnt <= cnt_sum;
        end
    end

endmodule

// File: rtl/bit_packer.sv
// Packs a stream of LANES-bit beats into WIDTH-bit words behind a one-word output
// buffer, with valid/ready handshakes on both sides.
module bit_packer
    import bit_packer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LANES     = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    bit_packer_if.slave  bus
);

    localparam int CW = cnt_w(WIDTH);

    if (WIDTH < 2 || LANES < 1 || (WIDTH % LANES) != 0) begin : g_bad_geometry
        $error("bit_packer: LANES must divide WIDTH and WIDTH must be >= 2");
    end

    beat_hs_t         hs;
    logic [CW-1:0]    cnt;
    logic             room;
    logic             in_ready;
    logic             accept;
    logic             done;
    logic [WIDTH-1:0] word_data;
    logic [CW-1:0]    word_count;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    out_count;

    assign hs = '{valid: bus.in_valid, last: bus.in_last};

    // A beat that cannot complete a word needs no buffer space, so it keeps
    // flowing even while the consumer stalls.
    assign room     = (int'(cnt) + LANES) < WIDTH;
    assign in_ready = rst_n && (!out_valid || bus.out_ready || (!hs.last && room));
    assign accept   = hs.valid && in_ready && !clear;

    bit_packer_accumulator #(
        .WIDTH     (WIDTH),
        .LANES     (LANES),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_accumulator (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .accept     (accept),
        .bits       (bus.in_bits),
        .last       (hs.last),
        .cnt        (cnt),
        .done       (done),
        .word_data  (word_data),
        .word_count (word_count)
    );

    // A completing beat overwrites the buffer even while it drains, so
    // back-to-back words leave no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (done) begin
            out_valid <= 1'b1;
            out_data  <= word_data;
            out_count <= word_count;
        end else if (bus.out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_count = out_count;

endmodule
